demux_dist: RTL and testbench
=============================

Name: demux_dist

Overview:
- Registered 1-to-32 distributor for 2-bit symbols: the write-side counterpart of the 32:1 selector.
- Accepts one symbol per cycle on a valid/ready input.
- Steers each symbol into one of 32 single-entry lane holding registers. Lane is chosen by an explicit select or by an internal round-robin pointer.
- Each lane presents its symbol with a valid flag until the lane's consumer acknowledges it.

Parameters:
- CNT_W, 16, width of the accepted-transfer counter (saturating).

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a symbol on in_data.
- in_ready  output  1  block accepts the symbol this cycle.
- in_data  input  2  symbol to distribute.
- sel  input  5  target lane when auto_mode=0; sampled with in_data.
- auto_mode  input  1  1 = target is the internal round-robin pointer; sel is ignored.
- out_data  output  64  lane k data on bits [2k+1:2k].
- out_valid  output  32  bit k = lane k holds an unconsumed symbol.
- out_ack  input  32  bit k = lane k consumer takes the symbol this cycle.
- ptr  output  5  current round-robin pointer.
- xfer_cnt  output  CNT_W  number of accepted symbols, saturating.

Behaviour:
- Reset (async, immediate on rst=1):
  - out_data=0, out_valid=0, ptr=0, xfer_cnt=0.
  - in_ready is combinational and therefore 0 while out_valid of the target is 1; after reset in_ready=1.
- Target lane: tgt = auto_mode ? ptr : sel.
- Acceptance:
  - in_ready = ~out_valid[tgt] | out_ack[tgt]. The target may free and refill in the same cycle.
  - Accept = in_valid & in_ready.
- On accept, at the next edge:
  - out_data[tgt] <= in_data.
  - out_valid[tgt] <= 1.
  - xfer_cnt increments unless already all-ones; it then holds.
  - If auto_mode=1, ptr <= ptr+1, wrapping 31 -> 0.
- Latency: symbol accepted at edge N is visible on its lane after edge N, i.e. 1 cycle.
- Lane release: out_ack[k] while out_valid[k]=1 clears out_valid[k] at the next edge, unless lane k is simultaneously the accepted target, in which case out_valid[k] stays 1 with the new data.
  - out_ack[k] while out_valid[k]=0 is ignored.
  - out_data[k] holds its last value after release and is not cleared.
- Multiple lanes may be acknowledged in one cycle. The 32 lanes are independent; only one lane can be written per cycle.
- Stall:
  - in_valid=1 and in_ready=0: nothing changes (ptr, counter, lanes).
  - Producer must hold in_data/sel stable until accept.
  - In auto_mode the pointer does not skip a full lane; it waits on it (strict in-order round robin).
- ptr advances only on accepted transfers in auto_mode. Switching auto_mode does not alter ptr.
- rst asserted mid-operation discards all held symbols and returns all state to reset values; no partial update survives.

Test Plan:
- Reset, then auto_mode=0, sel=5'd7, in_data=2'b10, in_valid one cycle -> in_ready=1; next cycle out_valid=32'h0000_0080, out_data[15:14]=2'b10, xfer_cnt=1, ptr=0.
- With lane 7 full and no ack, present sel=7, in_data=2'b01 -> in_ready=0 for every cycle; lane 7 keeps 2'b10, xfer_cnt stays 1. Then pulse out_ack[7] in the same cycle -> accept; lane 7 becomes 2'b01 and out_valid[7] remains 1.
- auto_mode=1, all acks held high, 33 consecutive symbols 0,1,2,3,0,... -> ptr walks 0..31 and wraps to 1. After symbol 33, lane 0 holds symbol 33's value (2'b00), xfer_cnt=33.
- auto_mode=1, no acks, 32 symbols -> out_valid=32'hFFFF_FFFF, ptr=0, in_ready=0. out_ack[0] alone -> one more accept into lane 0, ptr=1, then stall again.
- Acks out_ack=32'h0000_0005 with lanes 0 and 2 full and no input -> out_valid bits 0 and 2 clear next cycle; out_data unchanged. Ack on an empty lane -> no change.
- Mid-stream with several lanes full, assert rst between clock edges -> out_valid=0, ptr=0, xfer_cnt=0 immediately, before any clock edge. With CNT_W=4 forced, 20 accepts -> xfer_cnt saturates at 15.

Source files
------------

// File: rtl/demux_dist.sv
// Registered 1-to-32 distributor for 2-bit symbols: each accepted symbol lands in
// one single-entry lane register, chosen by sel or by an in-order round-robin pointer.
module demux_dist #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_data,
    input  logic [4:0]       sel,
    input  logic             auto_mode,
    output logic [63:0]      out_data,
    output logic [31:0]      out_valid,
    input  logic [31:0]      out_ack,
    output logic [4:0]       ptr,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The producer holds data/sel stable until then; ready never waits on valid.
    // Lane k's consumer takes its symbol on any edge where out_valid[k] and out_ack[k] are 1.

    logic [63:0]      data_q, data_d;
    logic [31:0]      valid_q, valid_d;
    logic [4:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       tgt;
    logic             accept;

    always_comb begin
        tgt      = auto_mode ? ptr_q : sel;
        // A full target lane being acknowledged this cycle can be refilled on the same edge.
        in_ready = ~valid_q[tgt] | out_ack[tgt];
        accept   = in_valid & in_ready;

        data_d  = data_q;
        valid_d = valid_q & ~out_ack;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d[tgt]              = 1'b1;
            data_d[{tgt, 1'b0} +: 2]  = in_data;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (auto_mode) begin
                ptr_d = ptr_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ptr       = ptr_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_dist.sv
// Directed bench for demux_dist: a default instance plus a CNT_W=4 instance on the
// same stimulus for counter saturation.
module tb_demux_dist;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_data;
    logic [4:0]  sel;
    logic        auto_mode;
    logic [63:0] out_data;
    logic [31:0] out_valid;
    logic [31:0] out_ack;
    logic [4:0]  ptr;
    logic [15:0] xfer_cnt;

    logic        in_ready_s;
    logic [63:0] out_data_s;
    logic [31:0] out_valid_s;
    logic [4:0]  ptr_s;
    logic [3:0]  xfer_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_dist dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sel(sel), .auto_mode(auto_mode),
        .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
        .ptr(ptr), .xfer_cnt(xfer_cnt)
    );

    demux_dist #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .sel(sel), .auto_mode(auto_mode),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_ack(out_ack),
        .ptr(ptr_s), .xfer_cnt(xfer_cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 2'b00; sel = 5'd0;
        auto_mode = 1'b0; out_ack = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_ptr", 64'(ptr), 64'h0);
        chk("rst_cnt", 64'(xfer_cnt), 64'h0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'h1);

        // Manual write into lane 7
        sel = 5'd7; in_data = 2'b10; in_valid = 1'b1;
        #1 chk("m_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("m_valid", 64'(out_valid), 64'h0000_0080);
        chk("m_data7", 64'(out_data[15:14]), 64'h2);
        chk("m_cnt", 64'(xfer_cnt), 64'h1);
        chk("m_ptr", 64'(ptr), 64'h0);

        // Full lane stalls; ack frees and refills in the same cycle
        in_data = 2'b01; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", 64'(in_ready), 64'h0);
            tick();
            chk("stall_data7", 64'(out_data[15:14]), 64'h2);
            chk("stall_cnt", 64'(xfer_cnt), 64'h1);
        end
        out_ack = 32'h0000_0080;
        #1 chk("refill_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0; out_ack = 32'h0;
        chk("refill_valid", 64'(out_valid), 64'h0000_0080);
        chk("refill_data7", 64'(out_data[15:14]), 64'h1);
        chk("refill_cnt", 64'(xfer_cnt), 64'h2);

        // Round robin with all acks high: 33 symbols 0,1,2,3,...
        auto_mode = 1'b1; out_ack = 32'hFFFF_FFFF; in_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            in_data = 2'(i % 4);
            #1;
            chk("rr_ptr", 64'(ptr), 64'(i % 32));
            chk("rr_ready", 64'(in_ready), 64'h1);
            tick();
        end
        in_valid = 1'b0; out_ack = 32'h0;
        chk("rr_ptr_wrap", 64'(ptr), 64'h1);
        chk("rr_valid", 64'(out_valid), 64'h0000_0001);
        chk("rr_data", out_data, 64'hE4E4_E4E4_E4E4_E4E4);
        chk("rr_cnt", 64'(xfer_cnt), 64'd35);
        chk("sat_cnt_a", 64'(xfer_cnt_s), 64'hF);

        // Drain, then fill every lane with no acks
        out_ack = 32'hFFFF_FFFF;
        tick();
        out_ack = 32'h0;
        chk("drain_valid", 64'(out_valid), 64'h0);
        in_data = 2'b11; in_valid = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        chk("fill_valid", 64'(out_valid), 64'hFFFF_FFFF);
        chk("fill_ptr", 64'(ptr), 64'h1);
        chk("fill_cnt", 64'(xfer_cnt), 64'd67);
        in_data = 2'b01;
        #1 chk("fill_ready", 64'(in_ready), 64'h0);
        // Ack a non-target lane: the pointer must wait on lane 1
        out_ack = 32'h0000_0001;
        #1 chk("skip_ready", 64'(in_ready), 64'h0);
        tick();
        chk("skip_ptr", 64'(ptr), 64'h1);
        chk("skip_valid", 64'(out_valid), 64'hFFFF_FFFE);
        out_ack = 32'h0000_0002;
        #1 chk("tgt_ack_ready", 64'(in_ready), 64'h1);
        tick();
        out_ack = 32'h0;
        chk("tgt_ptr", 64'(ptr), 64'h2);
        chk("tgt_valid", 64'(out_valid), 64'hFFFF_FFFE);
        chk("tgt_data", out_data, 64'hFFFF_FFFF_FFFF_FFF7);
        chk("tgt_cnt", 64'(xfer_cnt), 64'd68);
        #1 chk("restall_ready", 64'(in_ready), 64'h0);
        in_valid = 1'b0;

        // Multi-lane ack (lane 0 already empty), then ack of an empty lane
        out_ack = 32'h0000_0005;
        tick();
        chk("ack5_valid", 64'(out_valid), 64'hFFFF_FFFA);
        chk("ack5_data", out_data, 64'hFFFF_FFFF_FFFF_FFF7);
        out_ack = 32'h0000_0001;
        tick();
        out_ack = 32'h0;
        chk("ack_empty_valid", 64'(out_valid), 64'hFFFF_FFFA);
        chk("ack_empty_data", out_data, 64'hFFFF_FFFF_FFFF_FFF7);

        // Leaving auto mode keeps ptr; manual accept does not move it
        auto_mode = 1'b0;
        #1 chk("mode_ptr", 64'(ptr), 64'h2);
        sel = 5'd0; in_data = 2'b10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("man_ptr", 64'(ptr), 64'h2);
        chk("man_valid", 64'(out_valid), 64'hFFFF_FFFB);
        chk("man_data", out_data, 64'hFFFF_FFFF_FFFF_FFF6);
        chk("man_cnt", 64'(xfer_cnt), 64'd69);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_data", out_data, 64'h0);
        chk("arst_ptr", 64'(ptr), 64'h0);
        chk("arst_cnt", 64'(xfer_cnt), 64'h0);
        chk("arst_cnt_s", 64'(xfer_cnt_s), 64'h0);
        chk("arst_ready", 64'(in_ready), 64'h1);
        tick();
        rst = 1'b0;

        // 20 accepts: 4-bit counter saturates at 15
        out_ack = 32'hFFFF_FFFF; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sel = 5'(i);
            tick();
        end
        in_valid = 1'b0; out_ack = 32'h0;
        chk("sat_cnt_s", 64'(xfer_cnt_s), 64'hF);
        chk("sat_cnt", 64'(xfer_cnt), 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
